ahb_lite_sram_slave: RTL and testbench
======================================

# ahb_lite_sram_slave

AHB-Lite slave with a byte-addressable, flop-based memory behind it. It sits directly downstream of the `ahb_if` bus and consumes its address/control and data-phase signals. It returns HREADYOUT, HRESP and HRDATA with a configurable number of wait states and the two-cycle ERROR response. It is the default memory target for the master agent's self-checking benches.

## Interface
Parameters:
- ADDR_W, 32, HADDR width
- DATA_W, 32, HWDATA/HRDATA width; one of 8, 16, 32 or 64
- MEM_DEPTH, 1024, memory depth in DATA_W-wide words
- WAIT_STATES, 0, HREADYOUT-low cycles inserted per OKAY data phase; range 0..15

Ports:
- HCLK  in  1  clock; all logic on posedge
- HRESET  in  1  synchronous, active-high reset
- HSEL  in  1  slave select
- HADDR  in  ADDR_W  byte address
- HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
- HWRITE  in  1  1 = write
- HSIZE  in  3  transfer size, log2 of bytes
- HBURST  in  3  ignored
- HPROT  in  4  ignored
- HWDATA  in  DATA_W  write data, sampled in the data phase
- HREADY  in  1  global ready
- HREADYOUT  out  1  slave ready
- HRESP  out  2  OKAY=2'b00, ERROR=2'b01
- HRDATA  out  DATA_W  read data

## Operation
- Transfer accepted: at a posedge with HSEL & HREADY & HTRANS[1].
  - On acceptance, register addr, write, size and an err flag.
  - IDLE/BUSY, or HSEL=0, gives a zero-wait OKAY data phase with no memory effect.
- err is set when any of these hold:
  - HSIZE > log2(DATA_W/8);
  - HADDR is not aligned to 2^HSIZE;
  - word index HADDR[ADDR_W-1:log2(DATA_W/8)] ≥ MEM_DEPTH.
- FSM states: IDLE, WAIT, ERR1, ERR2.
  - IDLE: HREADYOUT=1, HRESP=OKAY. An accepted transfer moves to:
    - ERR1 if err;
    - else WAIT if WAIT_STATES>0 (counter loaded with WAIT_STATES);
    - else the data phase completes in the next cycle while staying in IDLE.
  - WAIT: HREADYOUT=0; the counter decrements each cycle. At 0, HREADYOUT=1 for the final data-phase cycle, then return to IDLE or accept the next transfer.
  - ERR1: HREADYOUT=0, HRESP=ERROR, then go to ERR2.
  - ERR2: HREADYOUT=1, HRESP=ERROR; new address-phase acceptance is allowed in this cycle, as normal.
- Writes:
  - Commit at the posedge ending the data phase (HREADYOUT=1, OKAY), using HWDATA from that cycle.
  - Byte enables come from size and addr[log2(DATA_W/8)-1:0], little-endian lanes.
  - Erroring writes never modify memory.
- Reads:
  - HRDATA = mem[addr_q] (full word, all lanes) in the OKAY read data phase; 0 otherwise, including IDLE, writes and ERROR.
- Write then read of the same address back-to-back returns the new data with no hazard logic: the write commits before the read's data phase.
- Memory is not reset.

## Timing
- Reset values: HREADYOUT=1, HRESP=OKAY, HRDATA=0, FSM=IDLE, wait counter=0. Any in-flight data phase is dropped and its pending write is discarded.
- Zero-wait latency: address phase at cycle N, data phase completes at cycle N+1. Back-to-back transfers sustain one per cycle.
- With WAIT_STATES=W: a data phase occupies W+1 cycles, with HREADYOUT low for the first W.
- ERROR always occupies exactly 2 cycles, independent of WAIT_STATES.
- During HREADYOUT=0 nothing new is accepted: HREADY is low.
- HRESET asserted during WAIT, ERR1 or ERR2 returns to IDLE on the next posedge.
- All outputs are registered or decoded from registered state only. There is no combinational path from HADDR/HTRANS to HREADYOUT or HRESP.

## Structure
- Shared package `ahb_pkg`:
  - htrans_e, hresp_e and hsize constants;
  - function `ahb_byte_en(size, addr_lsbs)`;
  - state typedef `ahb_slv_state_e`.
- Sub-module `ahb_sram_array`:
  - MEM_DEPTH × DATA_W flop array;
  - per-byte write enable;
  - asynchronous read port.
- The FSM and address-phase registers live in the top module.

## Test plan
- Write with WAIT_STATES=0, DATA_W=32:
  - stimulus: NONSEQ write word 0x010 with HWDATA 0xDEADBEEF, then NONSEQ read 0x010 back-to-back;
  - required: HREADYOUT stays 1, and HRDATA=0xDEADBEEF in the read data phase.
- Byte write:
  - stimulus: write byte (HSIZE=0) to 0x013 with HWDATA 0xAA000000, then read word 0x010;
  - required: 0xAAADBEEF.
- Wait states with WAIT_STATES=3:
  - stimulus: a single read;
  - required: HREADYOUT low for exactly 3 cycles, high on the 4th with correct HRDATA.
- Errors:
  - stimulus: write to 0x1000 (out of range, MEM_DEPTH=1024), then halfword write to 0x001 (unaligned);
  - required: each gives ERR1 (HREADYOUT=0, HRESP=01) then ERR2 (HREADYOUT=1, HRESP=01), and memory is unchanged.
- Non-transfers:
  - stimulus: IDLE/BUSY or HSEL=0 interleaved with a NONSEQ burst of 4 SEQ beats;
  - required: only the 4 beats modify memory, and OKAY responses with zero wait states.
- Reset mid-operation:
  - stimulus: assert HRESET during WAIT and during ERR1;
  - required: next cycle shows HREADYOUT=1, HRESP=00, HRDATA=0, and the pending write is absent from memory.

Source files
------------

// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB-Lite encodings and helpers shared by the SRAM slave and its
// memory array.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01
  } hresp_e;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  // Slave FSM: IDLE also covers the single data-phase cycle of a zero-wait
  // transfer; WAIT holds HREADYOUT low until the wait counter reaches zero.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } ahb_slv_state_e;

  // Little-endian byte-lane enables for a bus up to 64 bits wide. Sizes above
  // a doubleword never reach the array because they are flagged as errors.
  function automatic logic [7:0] ahb_byte_en(input logic [2:0] size,
                                             input logic [2:0] addr_lsbs);
    logic [7:0] lanes;
    case (size)
      HSIZE_BYTE: lanes = 8'h01;
      HSIZE_HALF: lanes = 8'h03;
      HSIZE_WORD: lanes = 8'h0F;
      default:    lanes = 8'hFF;
    endcase
    return lanes << addr_lsbs;
  endfunction

endpackage

// File: rtl/ahb_sram_array.sv
// ahb_sram_array: DEPTH x DATA_W flop memory with per-byte write enables and
// an asynchronous read port sharing the single address.
module ahb_sram_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int AW     = 10
) (
  input  logic                i_clk,
  input  logic [DATA_W/8-1:0] i_we,
  input  logic [AW-1:0]       i_addr,
  input  logic [DATA_W-1:0]   i_wdata,
  output logic [DATA_W-1:0]   o_rdata
);

  localparam int BYTES = DATA_W / 8;

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Byte-lane write; only enabled lanes of the addressed word change.
  // NOTE: the storage array has no reset on purpose -- clearing every word
  // would cost a reset fan-out to all flops and the contents are defined only
  // by writes anyway.
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < BYTES; b++) begin
      if (i_we[b]) begin
        r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// ahb_lite_sram_slave: AHB-Lite slave in front of a flop SRAM. Registers the
// address phase, inserts WAIT_STATES wait cycles per OKAY data phase, and
// signals the two-cycle ERROR response for illegal transfers.
module ahb_lite_sram_slave
  import ahb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [2:0]        HBURST,
  input  logic [3:0]        HPROT,
  input  logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  output logic              HREADYOUT,
  output logic [1:0]        HRESP,
  output logic [DATA_W-1:0] HRDATA
);

  localparam int BYTES = DATA_W / 8;
  localparam int LSB   = $clog2(BYTES);
  localparam int AW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int CNT_W = 4;

  ahb_slv_state_e    r_state;
  ahb_slv_state_e    w_state_nxt;
  ahb_slv_state_e    w_launch;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_size;
  logic              r_write;
  logic              r_act;
  logic              r_err;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_accept;
  logic              w_err;
  logic [2:0]        w_align_mask;
  logic              w_ready;
  logic              w_okay_final;
  logic [2:0]        w_lane;
  logic [7:0]        w_be8;
  logic [BYTES-1:0]  w_we;
  logic [AW-1:0]     w_word;
  logic [DATA_W-1:0] w_rdata;
  logic              w_unused;

  // A new address phase is taken only in a cycle where this slave is ready,
  // so a stray HREADY during our own wait cycles cannot corrupt state.
  assign w_accept = HSEL & HREADY & HTRANS[1] & w_ready;

  // Classify the address phase: oversize, misaligned or beyond the array.
  // NOTE: every signal driven in an always_comb gets a default at the top so
  // no path through the block leaves it unassigned and infers a latch.
  always_comb begin
    w_align_mask = 3'b000;
    case (HSIZE)
      HSIZE_BYTE: w_align_mask = 3'b000;
      HSIZE_HALF: w_align_mask = 3'b001;
      HSIZE_WORD: w_align_mask = 3'b011;
      default:    w_align_mask = 3'b111;
    endcase
    w_err = (HSIZE > 3'(LSB))
          | (|(HADDR[2:0] & w_align_mask))
          | ((HADDR >> LSB) >= ADDR_W'(MEM_DEPTH));
  end

  // FSM state register.
  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // its inputs from before the edge, independent of block ordering.
  always_ff @(posedge HCLK) begin
    if (HRESET) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next state: every ready cycle may launch the next transfer.
  always_comb begin
    w_launch = ST_IDLE;
    if (w_accept) begin
      if (w_err)                w_launch = ST_ERR1;
      else if (WAIT_STATES > 0) w_launch = ST_WAIT;
    end
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: w_state_nxt = w_launch;
      ST_WAIT: if (r_cnt == '0) w_state_nxt = w_launch;
      ST_ERR1: w_state_nxt = ST_ERR2;
      ST_ERR2: w_state_nxt = w_launch;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs, decoded purely from registered state.
  always_comb begin
    w_ready = 1'b1;
    HRESP   = HRESP_OKAY;
    case (r_state)
      ST_IDLE: w_ready = 1'b1;
      ST_WAIT: w_ready = (r_cnt == '0);
      ST_ERR1: begin
        w_ready = 1'b0;
        HRESP   = HRESP_ERROR;
      end
      ST_ERR2: begin
        w_ready = 1'b1;
        HRESP   = HRESP_ERROR;
      end
      default: w_ready = 1'b1;
    endcase
  end

  assign HREADYOUT = w_ready;

  // The last cycle of a non-erroring data phase: write commits, read returns.
  assign w_okay_final = w_ready & r_act & ~r_err;
  assign HRDATA       = (w_okay_final & ~r_write) ? w_rdata : '0;

  // Address-phase capture and wait counter; reset drops any data phase.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_addr  <= '0;
      r_size  <= '0;
      r_write <= 1'b0;
      r_act   <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      if (r_state == ST_WAIT && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      if (w_ready) begin
        r_act <= w_accept;
        r_err <= w_accept & w_err;
        if (w_accept) begin
          r_addr  <= HADDR;
          r_size  <= HSIZE;
          r_write <= HWRITE;
          r_cnt   <= CNT_W'(WAIT_STATES);
        end
      end
    end
  end

  assign w_word = r_addr[LSB +: AW];
  assign w_lane = r_addr[2:0] & 3'(BYTES - 1);
  assign w_be8  = ahb_byte_en(r_size, w_lane);
  assign w_we   = (w_okay_final & r_write) ? w_be8[BYTES-1:0] : '0;

  ahb_sram_array #(
    .DATA_W (DATA_W),
    .DEPTH  (MEM_DEPTH),
    .AW     (AW)
  ) u_array (
    .i_clk   (HCLK),
    .i_we    (w_we),
    .i_addr  (w_word),
    .i_wdata (HWDATA),
    .o_rdata (w_rdata)
  );

  // Burst type, protection and untouched address bits carry no meaning here.
  assign w_unused = ^{HBURST, HPROT, r_addr, w_be8};

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// tb_ahb_lite_sram_slave: two slaves (0 and 3 wait states) on a shared bus.
// Each sequence of beats is turned into an expected per-cycle response trace
// by a byte-level memory model, then driven and compared cycle by cycle.
module tb_ahb_lite_sram_slave;

  logic HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  logic        HRESET;
  logic        b_sel;
  int          cur;
  logic [31:0] b_addr;
  logic [31:0] b_wdata;
  logic [1:0]  b_trans;
  logic        b_write;
  logic [2:0]  b_size;

  logic        sel0, sel1, ro0, ro1;
  logic [1:0]  rs0, rs1;
  logic [31:0] rd0, rd1;

  assign sel0 = b_sel && (cur == 0);
  assign sel1 = b_sel && (cur == 1);

  ahb_lite_sram_slave #(
    .ADDR_W(32), .DATA_W(32), .MEM_DEPTH(1024), .WAIT_STATES(0)
  ) u_dut0 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(sel0), .HADDR(b_addr),
    .HTRANS(b_trans), .HWRITE(b_write), .HSIZE(b_size), .HBURST(3'b000),
    .HPROT(4'b0011), .HWDATA(b_wdata), .HREADY(ro0), .HREADYOUT(ro0),
    .HRESP(rs0), .HRDATA(rd0)
  );

  ahb_lite_sram_slave #(
    .ADDR_W(32), .DATA_W(32), .MEM_DEPTH(1024), .WAIT_STATES(3)
  ) u_dut3 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(sel1), .HADDR(b_addr),
    .HTRANS(b_trans), .HWRITE(b_write), .HSIZE(b_size), .HBURST(3'b001),
    .HPROT(4'b0011), .HWDATA(b_wdata), .HREADY(ro1), .HREADYOUT(ro1),
    .HRESP(rs1), .HRDATA(rd1)
  );

  typedef struct {
    bit        sel;
    bit [1:0]  trans;
    bit        write;
    bit [2:0]  size;
    bit [31:0] addr;
    bit [31:0] wdata;
  } beat_t;

  typedef struct {
    bit        ready;
    bit [1:0]  resp;
    bit        chk;
    bit [31:0] rdata;
  } exp_t;

  beat_t      bq[$];
  exp_t       eq[$];
  int         wait_of[2] = '{0, 3};
  logic [7:0] mem_m[2][64];
  int         total = 0;
  int         bad = 0;

  localparam bit [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;

  function automatic bit model_err(input bit [2:0] size, input bit [31:0] addr);
    return (size > 3'd2) || ((addr & ((32'd1 << size) - 32'd1)) != 32'd0)
        || ((addr >> 2) >= 32'd1024);
  endfunction

  function automatic bit [31:0] model_word(input int d, input bit [31:0] addr);
    int base;
    base = int'(addr & 32'h3C);
    return {mem_m[d][base+3], mem_m[d][base+2], mem_m[d][base+1], mem_m[d][base]};
  endfunction

  task automatic add(input bit sel, input bit [1:0] trans, input bit write,
                     input bit [2:0] size, input bit [31:0] addr, input bit [31:0] wdata);
    beat_t b;
    b.sel = sel; b.trans = trans; b.write = write;
    b.size = size; b.addr = addr; b.wdata = wdata;
    bq.push_back(b);
  endtask

  task automatic push_exp(input bit ready, input bit [1:0] resp, input bit chk,
                          input bit [31:0] rdata);
    exp_t e;
    e.ready = ready; e.resp = resp; e.chk = chk; e.rdata = rdata;
    eq.push_back(e);
  endtask

  // Build the expected trace from the model, then drive the beats pipelined.
  task automatic run_seq(input int d, input string name);
    int        idx;
    int        n;
    bit        rdy;
    bit [1:0]  rsp;
    logic [31:0] rdt;
    beat_t     b;
    add(1'b0, T_IDLE, 1'b0, 3'd0, 32'd0, 32'd0);
    n = bq.size();
    eq.delete();
    push_exp(1'b1, 2'b00, 1'b1, 32'd0);
    for (int i = 0; i < n; i++) begin
      b = bq[i];
      if (!(b.sel && b.trans[1])) begin
        push_exp(1'b1, 2'b00, 1'b1, 32'd0);
      end else if (model_err(b.size, b.addr)) begin
        push_exp(1'b0, 2'b01, 1'b1, 32'd0);
        push_exp(1'b1, 2'b01, 1'b1, 32'd0);
      end else begin
        repeat (wait_of[d]) push_exp(1'b0, 2'b00, 1'b0, 32'd0);
        if (b.write) begin
          for (int k = 0; k < (1 << b.size); k++) begin
            int a;
            a = int'(b.addr) + k;
            mem_m[d][a] = b.wdata[8*(a%4) +: 8];
          end
          push_exp(1'b1, 2'b00, 1'b1, 32'd0);
        end else begin
          push_exp(1'b1, 2'b00, 1'b1, model_word(d, b.addr));
        end
      end
    end

    cur = d;
    idx = 0;
    for (int k = 0; k < eq.size(); k++) begin
      if (idx < n) begin
        b_sel = bq[idx].sel; b_trans = bq[idx].trans; b_write = bq[idx].write;
        b_size = bq[idx].size; b_addr = bq[idx].addr;
      end else begin
        b_sel = 1'b0; b_trans = T_IDLE;
      end
      if (idx > 0 && idx <= n) b_wdata = bq[idx-1].wdata;
      else                     b_wdata = $urandom;
      @(negedge HCLK);
      rdy = (d == 1) ? ro1 : ro0;
      rsp = (d == 1) ? rs1 : rs0;
      rdt = (d == 1) ? rd1 : rd0;
      total++;
      if (rdy !== eq[k].ready) begin
        bad++;
        $display("FAIL %s cyc%0d HREADYOUT got %0b want %0b", name, k, rdy, eq[k].ready);
      end
      total++;
      if (rsp !== eq[k].resp) begin
        bad++;
        $display("FAIL %s cyc%0d HRESP got %0b want %0b", name, k, rsp, eq[k].resp);
      end
      if (eq[k].chk) begin
        total++;
        if (rdt !== eq[k].rdata) begin
          bad++;
          $display("FAIL %s cyc%0d HRDATA got %h want %h", name, k, rdt, eq[k].rdata);
        end
      end
      @(posedge HCLK);
      #1;
      if (rdy) idx++;
    end
    b_sel = 1'b0;
    b_trans = T_IDLE;
    total++;
    if (idx != n + 1) begin
      bad++;
      $display("FAIL %s beats completed got %0d want %0d", name, idx, n + 1);
    end
    bq.delete();
  endtask

  task automatic check_outputs(input int d, input string name, input bit ready,
                               input bit [1:0] resp, input bit chk_data);
    bit       rdy;
    bit [1:0] rsp;
    logic [31:0] rdt;
    rdy = (d == 1) ? ro1 : ro0;
    rsp = (d == 1) ? rs1 : rs0;
    rdt = (d == 1) ? rd1 : rd0;
    total++;
    if (rdy !== ready) begin
      bad++;
      $display("FAIL %s HREADYOUT got %0b want %0b", name, rdy, ready);
    end
    total++;
    if (rsp !== resp) begin
      bad++;
      $display("FAIL %s HRESP got %0b want %0b", name, rsp, resp);
    end
    if (chk_data) begin
      total++;
      if (rdt !== 32'd0) begin
        bad++;
        $display("FAIL %s HRDATA got %h want 00000000", name, rdt);
      end
    end
  endtask

  task automatic test_reset();
    HRESET = 1'b1;
    b_sel = 1'b0; b_trans = T_IDLE; b_write = 1'b0; b_size = 3'd0;
    b_addr = 32'd0; b_wdata = 32'd0; cur = 0;
    repeat (3) @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    @(negedge HCLK);
    check_outputs(0, "reset_dut0", 1'b1, 2'b00, 1'b1);
    check_outputs(1, "reset_dut3", 1'b1, 2'b00, 1'b1);
    @(posedge HCLK);
    #1;
  endtask

  task automatic test_fill();
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 16; w++) add(1'b1, T_NSEQ, 1'b1, 3'd2, 32'(4*w), $urandom);
      run_seq(d, "fill");
    end
  endtask

  task automatic test_write_read();
    add(1'b1, T_NSEQ, 1'b1, 3'd2, 32'h010, 32'hDEADBEEF);
    add(1'b1, T_NSEQ, 1'b0, 3'd2, 32'h010, $urandom);
    run_seq(0, "write_read");
  endtask

  task automatic test_byte_write();
    add(1'b1, T_NSEQ, 1'b1, 3'd0, 32'h013, 32'hAA000000);
    add(1'b1, T_NSEQ, 1'b0, 3'd2, 32'h010, 32'd0);
    run_seq(0, "byte_write");
  endtask

  task automatic test_wait_states();
    add(1'b1, T_NSEQ, 1'b0, 3'd2, 32'h008, 32'd0);
    run_seq(1, "wait_read");
    add(1'b1, T_NSEQ, 1'b1, 3'd1, 32'h00A, 32'h5A5A_1234);
    add(1'b1, T_NSEQ, 1'b0, 3'd2, 32'h008, 32'd0);
    run_seq(1, "wait_half");
  endtask

  task automatic test_errors();
    for (int d = 0; d < 2; d++) begin
      add(1'b1, T_NSEQ, 1'b1, 3'd2, 32'h1000, $urandom);
      add(1'b1, T_NSEQ, 1'b1, 3'd1, 32'h001, $urandom);
      add(1'b1, T_NSEQ, 1'b1, 3'd3, 32'h000, $urandom);
      add(1'b1, T_NSEQ, 1'b0, 3'd2, 32'h1000, 32'd0);
      add(1'b1, T_NSEQ, 1'b0, 3'd2, 32'h000, 32'd0);
      add(1'b1, T_NSEQ, 1'b0, 3'd2, 32'h000, 32'd0);
      run_seq(d, "errors");
    end
  endtask

  task automatic test_non_transfers();
    for (int d = 0; d < 2; d++) begin
      add(1'b1, T_NSEQ, 1'b1, 3'd2, 32'h020, $urandom);
      add(1'b1, T_BUSY, 1'b1, 3'd2, 32'h024, $urandom);
      add(1'b1, T_SEQ,  1'b1, 3'd2, 32'h024, $urandom);
      add(1'b1, T_IDLE, 1'b1, 3'd2, 32'h030, $urandom);
      add(1'b0, T_NSEQ, 1'b1, 3'd2, 32'h030, $urandom);
      add(1'b1, T_SEQ,  1'b1, 3'd2, 32'h028, $urandom);
      add(1'b1, T_BUSY, 1'b1, 3'd2, 32'h034, $urandom);
      add(1'b1, T_SEQ,  1'b1, 3'd2, 32'h02C, $urandom);
      for (int w = 8; w < 14; w++) add(1'b1, T_NSEQ, 1'b0, 3'd2, 32'(4*w), 32'd0);
      run_seq(d, "non_transfers");
    end
  endtask

  task automatic test_back_to_back();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 6; i++) begin
        add(1'b1, T_NSEQ, 1'b1, 3'(i % 3), 32'h018, $urandom);
        add(1'b1, T_NSEQ, 1'b0, 3'd2, 32'h018, 32'd0);
      end
      run_seq(d, "back_to_back");
    end
  endtask

  task automatic test_random();
    bit        s;
    bit [1:0]  t;
    bit        w;
    bit [2:0]  sz;
    bit [31:0] a;
    int        pick;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 60; i++) begin
        s  = ($urandom_range(0, 9) != 0);
        t  = 2'($urandom_range(0, 3));
        w  = 1'($urandom_range(0, 1));
        sz = ($urandom_range(0, 15) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
        a  = 32'($urandom_range(0, 63));
        pick = int'($urandom_range(0, 15));
        if (pick == 0)     a = 32'h1000 + a;
        else if (pick > 2) a = a & ~((32'd1 << sz) - 32'd1);
        add(s, t, w, sz, a, $urandom);
      end
      for (int k = 0; k < 16; k++) add(1'b1, T_NSEQ, 1'b0, 3'd2, 32'(4*k), 32'd0);
      run_seq(d, "random");
    end
  endtask

  task automatic test_reset_mid();
    bit [31:0] old;
    // Reset while the 3-wait slave is holding a write in WAIT.
    old = model_word(1, 32'h03C);
    cur = 1;
    b_sel = 1'b1; b_trans = T_NSEQ; b_write = 1'b1; b_size = 3'd2; b_addr = 32'h03C;
    b_wdata = ~old;
    @(posedge HCLK);
    #1;
    b_sel = 1'b0; b_trans = T_IDLE;
    @(negedge HCLK);
    check_outputs(1, "rst_wait_before", 1'b0, 2'b00, 1'b0);
    HRESET = 1'b1;
    @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    @(negedge HCLK);
    check_outputs(1, "rst_wait_after", 1'b1, 2'b00, 1'b1);
    @(posedge HCLK);
    #1;
    add(1'b1, T_NSEQ, 1'b0, 3'd2, 32'h03C, 32'd0);
    run_seq(1, "rst_wait_readback");

    // Reset during ERR1 of the zero-wait slave.
    cur = 0;
    b_sel = 1'b1; b_trans = T_NSEQ; b_write = 1'b1; b_size = 3'd1; b_addr = 32'h005;
    b_wdata = $urandom;
    @(posedge HCLK);
    #1;
    b_sel = 1'b0; b_trans = T_IDLE;
    @(negedge HCLK);
    check_outputs(0, "rst_err1_before", 1'b0, 2'b01, 1'b0);
    HRESET = 1'b1;
    @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    @(negedge HCLK);
    check_outputs(0, "rst_err1_after", 1'b1, 2'b00, 1'b1);
    @(posedge HCLK);
    #1;
    add(1'b1, T_NSEQ, 1'b0, 3'd2, 32'h004, 32'd0);
    add(1'b1, T_NSEQ, 1'b1, 3'd2, 32'h004, 32'h0BAD_F00D);
    add(1'b1, T_NSEQ, 1'b0, 3'd2, 32'h004, 32'd0);
    run_seq(0, "rst_err1_readback");
  endtask

  initial begin
    test_reset();
    test_fill();
    test_write_read();
    test_byte_write();
    test_wait_states();
    test_errors();
    test_non_transfers();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
